// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and divisor helper for the clock divider.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package clk_div_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned DIV_1KHZ  = 24999;
  localparam int unsigned DIV_100HZ = 249999;
  localparam int unsigned DEF_CNT_W = 16;

  // Half-period-minus-one divisor that produces the requested output frequency.
  function automatic int unsigned div_for(input int unsigned hz);
    return CLK_HZ / (2 * hz) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel: active/shadow divisor, pending flag,
//                down-counter, square-wave output and rising-edge tick.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DIV_1KHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_data,
  output logic             o_clkout,
  output logic             o_tick,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_commit_div;
  logic [CNT_W-1:0] w_sync_div;

  // Divisor to load at a reload; sync additionally honours a same-cycle write.
  always_comb begin
    w_commit_div = r_pending ? r_shd : r_div;
    w_sync_div   = i_wr ? i_wr_data : w_commit_div;
  end

  // Channel state: hold > sync > terminal count > decrement; writes only touch shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= c_def_div;
      r_shd     <= c_def_div;
      r_cnt     <= c_def_div;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= r_div;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      if (i_wr) begin
        r_shd     <= i_wr_data;
        r_pending <= 1'b1;
      end
    end else if (i_sync) begin
      r_div     <= w_sync_div;
      r_shd     <= w_sync_div;
      r_cnt     <= w_sync_div;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else if (r_cnt == '0) begin
      // Old shadow commits now; a write in this same cycle waits for the next reload.
      r_div  <= w_commit_div;
      r_cnt  <= w_commit_div;
      r_clk  <= ~r_clk;
      r_tick <= ~r_clk;
      if (i_wr) begin
        r_shd     <= i_wr_data;
        r_pending <= 1'b1;
      end else begin
        r_pending <= 1'b0;
      end
    end else begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_tick <= 1'b0;
      if (i_wr) begin
        r_shd     <= i_wr_data;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_clkout = r_clk;
  assign o_tick   = r_tick;
  assign o_busy   = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : NCH-channel programmable clock divider / tick generator with
//                glitch-free divisor updates, per-channel enables and sync.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DIV_1KHZ,
  parameter bit          EN_RST      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_data,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  logic           r_en_seen;
  logic [NCH-1:0] w_en_mask;
  logic [NCH-1:0] w_en;

  // Marks that en has been sampled at least once since reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_seen <= 1'b0;
    end else begin
      r_en_seen <= 1'b1;
    end
  end

  // Reset-time enable mask governs until en is first sampled.
  always_comb begin
    w_en_mask = r_en_seen ? {NCH{1'b1}} : {NCH{EN_RST}};
    w_en      = en & w_en_mask;
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic w_wr_hit;
      // Out-of-range channel indices never match, so such writes are dropped.
      assign w_wr_hit = wr_en && (wr_ch == 3'(i));

      clk_div_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_en[i]),
        .i_sync    (sync),
        .i_wr      (w_wr_hit),
        .i_wr_data (wr_data),
        .o_clkout  (clkout[i]),
        .o_tick    (tick[i]),
        .o_busy    (busy[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Directed self-checking bench for clk_div_multi (DEFAULT_DIV=3).
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module tb_clk_div_multi;

  localparam int NCH   = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             wr_en;
  logic [2:0]       wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] e_c0_a, e_t0_a, e_c1_a, e_t1_a, e_b1_a;
  logic [7:0] e_c0_b, e_t0_b, e_b0_b, e_c1_b;

  clk_div_multi #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (3),
    .EN_RST      (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .clkout  (clkout),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: returns just after the falling edge following a rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 2'b11; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    #1 reset = 1'b1;
    #2;
    check_val("rst_clkout", 32'(clkout), 32'h0);
    check_val("rst_tick",   32'(tick),   32'h0);
    check_val("rst_busy",   32'(busy),   32'h0);
    cyc(); cyc();
    reset = 1'b0;

    // Default divisor 3: rise at edge 4, period 8, tick at 4, 12, 20.
    for (int n = 1; n <= 20; n++) begin
      cyc();
      check_val("def_clk0",  32'(clkout[0]), 32'((n / 4) % 2));
      check_val("def_clk1",  32'(clkout[1]), 32'((n / 4) % 2));
      check_val("def_tick0", 32'(tick[0]),   32'(n % 8 == 4));
      check_val("def_tick1", 32'(tick[1]),   32'(n % 8 == 4));
    end

    // Mid-period write of divisor 1 to ch1 (bit k = edge 21+k).
    e_c1_a = 10'b1001100111; e_t1_a = 10'b1000100000; e_b1_a = 10'b0000000111;
    e_c0_a = 10'b1110000111; e_t0_a = 10'b0010000000;
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 16'd1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      wr_en = 1'b0;
      check_val("wr_clk1",  32'(clkout[1]), 32'(e_c1_a[k]));
      check_val("wr_tick1", 32'(tick[1]),   32'(e_t1_a[k]));
      check_val("wr_busy1", 32'(busy[1]),   32'(e_b1_a[k]));
      check_val("wr_clk0",  32'(clkout[0]), 32'(e_c0_a[k]));
      check_val("wr_tick0", 32'(tick[0]),   32'(e_t0_a[k]));
    end

    // Out-of-range channel write, then divisor 0 on ch0 landing at a terminal count.
    wr_en = 1'b1; wr_ch = 3'd5; wr_data = 16'd7;
    cyc();
    check_val("oob_busy", 32'(busy), 32'h0);
    wr_ch = 3'd0; wr_data = 16'd0;
    cyc();
    wr_en = 1'b0;
    check_val("d0_busy_wr", 32'(busy), 32'h1);
    check_val("d0_clk0_wr", 32'(clkout[0]), 32'h0);
    e_c0_b = 8'b10101000; e_t0_b = 8'b10101000; e_b0_b = 8'b00000111; e_c1_b = 8'b01100110;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check_val("d0_clk0",  32'(clkout[0]), 32'(e_c0_b[k]));
      check_val("d0_tick0", 32'(tick[0]),   32'(e_t0_b[k]));
      check_val("d0_busy0", 32'(busy[0]),   32'(e_b0_b[k]));
      check_val("oob_clk1", 32'(clkout[1]), 32'(e_c1_b[k]));
    end

    // Hold ch0 for 10 cycles while high; write divisor 3 during the hold.
    en = 2'b10;
    for (int n = 41; n <= 50; n++) begin
      cyc();
      check_val("hold_clk0",  32'(clkout[0]), 32'h0);
      check_val("hold_tick0", 32'(tick[0]),   32'h0);
      if (n == 44) begin
        wr_en = 1'b1; wr_ch = 3'd0; wr_data = 16'd3;
      end
      if (n == 45) wr_en = 1'b0;
    end
    check_val("hold_busy0", 32'(busy[0]), 32'h1);
    en = 2'b11;
    cyc();
    check_val("rel_clk0",  32'(clkout[0]), 32'h1);
    check_val("rel_tick0", 32'(tick[0]),   32'h1);
    check_val("rel_busy0", 32'(busy[0]),   32'h0);
    for (int n = 52; n <= 59; n++) begin
      cyc();
      check_val("rel_clk0_run",  32'(clkout[0]), 32'(n < 55 || n == 59));
      check_val("rel_tick0_run", 32'(tick[0]),   32'(n == 59));
    end

    // Sync with a same-cycle write of divisor 5 to ch1.
    sync = 1'b1; wr_en = 1'b1; wr_ch = 3'd1; wr_data = 16'd5;
    cyc();
    sync = 1'b0; wr_en = 1'b0;
    check_val("sync_clk",  32'(clkout), 32'h0);
    check_val("sync_tick", 32'(tick),   32'h0);
    check_val("sync_busy", 32'(busy),   32'h0);
    for (int n = 61; n <= 66; n++) begin
      cyc();
      check_val("sync_clk0",  32'(clkout[0]), 32'(n >= 64));
      check_val("sync_tick0", 32'(tick[0]),   32'(n == 64));
      check_val("sync_clk1",  32'(clkout[1]), 32'(n >= 66));
      check_val("sync_tick1", 32'(tick[1]),   32'(n == 66));
    end

    // Asynchronous reset between edges while ch0 is high with a pending write.
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 16'd9;
    cyc();
    wr_en = 1'b0;
    check_val("pre_busy0", 32'(busy[0]),   32'h1);
    check_val("pre_clk0",  32'(clkout[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_clkout", 32'(clkout), 32'h0);
    check_val("arst_tick",   32'(tick),   32'h0);
    check_val("arst_busy",   32'(busy),   32'h0);
    cyc(); cyc();
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      cyc();
      check_val("post_clk0",  32'(clkout[0]), 32'(n == 4));
      check_val("post_tick0", 32'(tick[0]),   32'(n == 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
